// File: rtl/stopwatch_mmss.sv
// stopwatch_mmss: MM:SS BCD stopwatch advanced by synchronised rising edges of a 1 Hz tick, with start/stop/clear/lap control.
module stopwatch_mmss #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_active,
  output logic       rollover
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  localparam logic [3:0][3:0] MX = {4'd5, 4'd9, 4'd5, 4'd9};
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic prev, adv, inc;
  logic [3:0] cy;
  logic [3:0][3:0] live, snap, live_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tick_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end
  assign adv = sync[SYNC_STAGES-1] & ~prev;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = clear ? IDLE : start_stop ? (state == RUN ? PAUSED : RUN) : state;
  end
  always_comb begin
    running = state == RUN;
    {min_tens, min_ones, sec_tens, sec_ones} = lap_active ? snap : live;
  end
  // cy[i] means digit i advances this cycle; it wraps to zero when already at its maximum
  assign inc = adv && state == RUN;
  assign cy = {cy[2] && live[2] == MX[2], cy[1] && live[1] == MX[1], cy[0] && live[0] == MX[0], inc};
  always_comb begin
    live_nx = live;
    for (int i = 0; i < 4; i++) live_nx[i] = !cy[i] ? live[i] : live[i] == MX[i] ? 4'd0 : live[i] + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      live <= '0;
      snap <= '0;
      lap_active <= 1'b0;
      rollover <= 1'b0;
    end else begin
      live <= live_nx;
      rollover <= cy[3] && live[3] == MX[3];
      if (lap && lap_active) lap_active <= 1'b0;
      else if (lap && state == RUN) begin
        snap <= live_nx;
        lap_active <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stopwatch_mmss.sv
// tb_stopwatch_mmss: directed stimulus against a seconds-count model plus literal time checkpoints.
module tb_stopwatch_mmss;
  localparam int S = 2;
  logic clk = 0, reset = 1, tick_in = 0, start_stop = 0, clear = 0, lap = 0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic running, lap_active, rollover;
  int checks = 0, errors = 0, roll_cnt = 0;
  int m_secs = 0, m_snap = 0, m_lap = 0, m_st = 0, m_roll = 0;
  int hist [S+1];

  stopwatch_mmss #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop), .clear(clear), .lap(lap),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .lap_active(lap_active), .rollover(rollover)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time is a plain seconds count; a tick is seen S edges after it is sampled high.
  always @(posedge clk) begin
    int adv, inc, nsecs;
    if (reset) begin
      m_secs = 0; m_snap = 0; m_lap = 0; m_st = 0; m_roll = 0;
      foreach (hist[i]) hist[i] = 0;
    end else begin
      adv = (hist[S-1] == 1 && hist[S] == 0) ? 1 : 0;
      inc = (adv == 1 && m_st == 1) ? 1 : 0;
      nsecs = inc ? (m_secs + 1) % 3600 : m_secs;
      m_roll = (inc == 1 && m_secs == 3599) ? 1 : 0;
      if (clear) begin
        m_secs = 0; m_snap = 0; m_lap = 0; m_st = 0; m_roll = 0;
      end else begin
        m_secs = nsecs;
        if (lap && m_lap == 1) m_lap = 0;
        else if (lap && m_st == 1) begin m_snap = nsecs; m_lap = 1; end
        if (start_stop) m_st = (m_st == 1) ? 2 : 1;
      end
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(tick_in);
    end
  end

  always @(posedge clk) begin
    int d;
    #1;
    d = m_lap ? m_snap : m_secs;
    chk("sec_ones", int'(sec_ones), d % 10);
    chk("sec_tens", int'(sec_tens), (d % 60) / 10);
    chk("min_ones", int'(min_ones), (d / 60) % 10);
    chk("min_tens", int'(min_tens), d / 600);
    chk("running", int'(running), int'(m_st == 1));
    chk("lap_active", int'(lap_active), m_lap);
    chk("rollover", int'(rollover), m_roll);
    if (rollover === 1'b1) roll_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n, input int half);
    repeat (n) begin
      tick_in = 1; cyc(half);
      tick_in = 0; cyc(half);
    end
  endtask

  task automatic pulse(input logic ss, input logic cl, input logic lp);
    start_stop = ss; clear = cl; lap = lp;
    cyc(1);
    start_stop = 0; clear = 0; lap = 0;
  endtask

  task automatic tick_ss();
    tick_in = 1; cyc(2);
    start_stop = 1; cyc(1);
    start_stop = 0; cyc(7);
    tick_in = 0; cyc(10);
  endtask

  task automatic lit(input string name, input int mm, input int ss);
    chk(name, int'({min_tens, min_ones, sec_tens, sec_ones}),
        int'({4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)}));
  endtask

  initial begin
    cyc(2);
    reset = 0;
    cyc(1);
    lit("lit_reset", 0, 0);
    chk("lit_reset_run", int'(running), 0);
    pulse(1, 0, 0);
    chk("lit_start_run", int'(running), 1);
    tick_in = 1; cyc(2);
    chk("lit_lat2", int'(sec_ones), 0);
    cyc(1);
    chk("lit_lat3", int'(sec_ones), 1);
    cyc(7); tick_in = 0; cyc(10);
    ticks(2, 10);
    lit("lit_0003", 0, 3);
    ticks(2, 10);
    tick_ss();
    lit("lit_pause", 0, 6);
    chk("lit_paused_run", int'(running), 0);
    ticks(4, 10);
    lit("lit_paused_hold", 0, 6);
    tick_ss();
    lit("lit_resume", 0, 6);
    chk("lit_resume_run", int'(running), 1);
    ticks(4, 10);
    lit("lit_0010", 0, 10);
    pulse(0, 0, 1);
    ticks(5, 10);
    lit("lit_lap_hold", 0, 10);
    chk("lit_lap_on", int'(lap_active), 1);
    pulse(0, 0, 1);
    lit("lit_lap_release", 0, 15);
    ticks(135, 3);
    lit("lit_0230", 2, 30);
    pulse(0, 0, 1);
    pulse(1, 1, 0);
    lit("lit_clear", 0, 0);
    chk("lit_clear_run", int'(running), 0);
    chk("lit_clear_lap", int'(lap_active), 0);
    pulse(1, 0, 0);
    ticks(59, 3);
    lit("lit_0059", 0, 59);
    ticks(1, 3);
    lit("lit_0100", 1, 0);
    ticks(3539, 3);
    lit("lit_5959", 59, 59);
    roll_cnt = 0;
    ticks(1, 3);
    lit("lit_wrap", 0, 0);
    chk("lit_roll_cnt", roll_cnt, 1);
    chk("lit_wrap_run", int'(running), 1);
    tick_in = 1; reset = 1; cyc(2);
    reset = 0; cyc(4);
    tick_in = 0; cyc(4);
    lit("lit_tick_reset", 0, 0);
    pulse(1, 0, 0);
    ticks(754, 3);
    lit("lit_1234", 12, 34);
    reset = 1; cyc(1);
    lit("lit_midreset", 0, 0);
    chk("lit_midreset_flags", int'({running, lap_active, rollover}), 0);
    reset = 0; cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_mmss.md
Name: stopwatch_mmss

Overview:
- Consumes the slow square-wave clock produced by the 10 MHz-to-1 Hz clock divider and turns it into an MM:SS elapsed-time count.
- The divider output is treated as data, not as a clock: it is synchronised into the system clock domain and rising-edge detected, and each detected edge advances the time by one second.
- A start/stop/clear/lap control FSM gates the count.
- Outputs are four BCD digits for the downstream 7-segment driver.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the tick_in synchroniser (legal values: 2 or more)

Ports:
clk  input  1  system clock (10 MHz)
reset  input  1  synchronous, active-high reset
tick_in  input  1  divided 1 Hz square wave; each rising edge is one second
start_stop  input  1  single-cycle pulse; toggles between run and pause
clear  input  1  single-cycle pulse; returns to idle with the count at zero
lap  input  1  single-cycle pulse; toggles the display freeze
sec_ones  output  4  BCD seconds units, 0-9
sec_tens  output  4  BCD seconds tens, 0-5
min_ones  output  4  BCD minutes units, 0-9
min_tens  output  4  BCD minutes tens, 0-5
running  output  1  high while the state is RUN
lap_active  output  1  high while the display is frozen
rollover  output  1  single-cycle pulse on the 59:59 -> 00:00 wrap

Behaviour:
- Reset (sampled on the clk rising edge while reset=1):
  - state = IDLE; all live and snapshot digits = 0.
  - Synchroniser flops and edge-detect register = 0.
  - running = 0, lap_active = 0, rollover = 0.
- Tick path:
  - tick_in passes through SYNC_STAGES flops, then into a previous-value register.
  - adv = sync_out & ~prev.
  - A digit update is visible SYNC_STAGES+1 clk cycles after tick_in rises.
  - Exactly one adv per tick_in rising edge. No adv on a falling edge.
- FSM states: IDLE, RUN, PAUSED.
  - IDLE --start_stop--> RUN
  - RUN --start_stop--> PAUSED
  - PAUSED --start_stop--> RUN
  - any state --clear--> IDLE: live digits and snapshot digits = 0, lap_active = 0.
  - clear has priority over start_stop and lap in the same cycle.
- Counting:
  - The live count increments only when adv=1 and the current (pre-transition) state is RUN.
  - adv in the same cycle as a RUN->PAUSED start_stop is counted.
  - adv in the same cycle as a PAUSED/IDLE->RUN start_stop is not counted.
- BCD arithmetic:
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
  - min_tens 5 -> 0 at 59:59 wraps to 00:00; rollover=1 for exactly the one cycle in which the wrapped value is registered. Counting continues.
  - No digit ever leaves its range (sec_tens and min_tens never exceed 5; units never exceed 9).
- Lap:
  - lap in RUN with lap_active=0: snapshot <= live count (including any increment in the same cycle); lap_active <= 1.
  - lap with lap_active=1, in any state: lap_active <= 0.
  - lap in IDLE or PAUSED with lap_active=0: ignored.
  - While lap_active=1, the outputs show the snapshot and the live count keeps running internally.
  - While lap_active=0, the outputs show the live count.
- Outputs and flags:
  - All outputs are registered.
  - running = (state == RUN), updating in the cycle after the transition.
  - rollover is the live-count wrap and is independent of lap.
- Reset mid-operation: identical to a power-on reset regardless of the current state. A tick_in that is high at reset release may produce one adv; this is harmless because the state is IDLE.

Test Plan:
- Reset, then start_stop, then 3 tick_in rising edges (tick period 20 cycles, SYNC_STAGES=2) -> digits 00:03; each digit update occurs 3 cycles after the tick rises; running=1.
- Preload by running 59 ticks, then 1 more -> 00:59 becomes 01:00. Run to 59:59, then 1 more tick -> 00:00, rollover high for exactly 1 cycle, running stays 1.
- At 00:05 in RUN, assert start_stop coincident with adv -> 00:06, state PAUSED. Apply 4 more ticks -> digits remain 00:06. start_stop coincident with adv -> 00:06, state RUN.
- Lap at 00:10 in RUN, then 5 ticks -> outputs hold 00:10 with lap_active=1. Second lap -> outputs show 00:15 the next cycle.
- clear and start_stop in the same cycle at 02:30 in RUN -> state IDLE, digits 00:00, running=0, lap_active=0.
- Hold tick_in at 1 through a reset pulse, with no start_stop -> digits stay 00:00; assert reset mid-count at 12:34 -> all outputs 0 on the next cycle.
